// File: rtl/mmse_ram_arb_if.sv
// Client-side bundle for mmse_ram_arb: two write streams, equaliser read, sweep control/return.
interface mmse_ram_arb_if #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  mmse_wr_vld;
  logic [RAM_WIDTH-1:0]  mmse_din;
  logic                  mmse_wr_rdy;
  logic                  avg_wr_vld;
  logic [RAM_WIDTH-1:0]  avg_din;
  logic                  avg_wr_rdy;
  logic                  eq_rd_en;
  logic [ADDR_WIDTH-1:0] eq_rd_addr;
  logic                  eq_rd_rdy;
  logic                  eq_rd_vld;
  logic [RAM_WIDTH-1:0]  eq_ram_dout;
  logic                  eq_addr_err;
  logic                  ch_avg_start;
  logic                  avg_rd_vld;
  logic [RAM_WIDTH-1:0]  avg_ram_dout;
  logic                  avg_rd_done;
  logic                  sweep_busy;

  modport master (
    output mmse_wr_vld, mmse_din, avg_wr_vld, avg_din, eq_rd_en, eq_rd_addr, ch_avg_start,
    input  mmse_wr_rdy, avg_wr_rdy, eq_rd_rdy, eq_rd_vld, eq_ram_dout, eq_addr_err,
           avg_rd_vld, avg_ram_dout, avg_rd_done, sweep_busy
  );

  modport slave (
    input  mmse_wr_vld, mmse_din, avg_wr_vld, avg_din, eq_rd_en, eq_rd_addr, ch_avg_start,
    output mmse_wr_rdy, avg_wr_rdy, eq_rd_rdy, eq_rd_vld, eq_ram_dout, eq_addr_err,
           avg_rd_vld, avg_ram_dout, avg_rd_done, sweep_busy
  );
endinterface

// File: rtl/mmse_ram_arb.sv
// Shared single-port RAM (MMSE region + channel-average region), four clients, fixed priority.
// Define MMSE_RAM_STALL_CNT_EN to add the saturating stall_cnt port.
module mmse_ram_arb #(
  parameter int RAM_WIDTH  = 32,
  parameter int MMSE_DEPTH = 576,
  parameter int AVG_DEPTH  = 240,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  mmse_ram_arb_if.slave bus
`ifdef MMSE_RAM_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  localparam int TOTAL_DEPTH = MMSE_DEPTH + AVG_DEPTH;
  localparam logic [ADDR_WIDTH-1:0] MMSE_LAST  = ADDR_WIDTH'(MMSE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AVG_BASE   = ADDR_WIDTH'(MMSE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AVG_LAST   = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(TOTAL_DEPTH);

  typedef enum logic {S_IDLE, S_SWEEP} sweep_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_EQ, TAG_SW} rd_tag_t;

  sweep_state_t          state_q, state_nxt;
  rd_tag_t               tag_q;
  logic [ADDR_WIDTH-1:0] mmse_ptr, avg_ptr, sw_addr, sw_addr_nxt;
  logic                  done_nxt, done_q, err_q;
  logic                  sw_req, gnt_mw, gnt_aw, gnt_eq, gnt_sw, eq_in_range;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [RAM_WIDTH-1:0]  ram_din, ram_q;
  logic [RAM_WIDTH-1:0]  eq_dout, avg_dout, eq_hold_q, avg_hold_q;
  logic [RAM_WIDTH-1:0]  mem [TOTAL_DEPTH];

  always_comb begin
    sw_req      = (state_q == S_SWEEP);
    gnt_mw      = bus.mmse_wr_vld;
    gnt_aw      = bus.avg_wr_vld & ~bus.mmse_wr_vld;
    gnt_eq      = bus.eq_rd_en & ~bus.mmse_wr_vld & ~bus.avg_wr_vld;
    gnt_sw      = sw_req & ~bus.mmse_wr_vld & ~bus.avg_wr_vld & ~bus.eq_rd_en;
    eq_in_range = ({1'b0, bus.eq_rd_addr} < ADDR_LIMIT);
  end

  assign bus.mmse_wr_rdy = gnt_mw;
  assign bus.avg_wr_rdy  = gnt_aw;
  assign bus.eq_rd_rdy   = gnt_eq;

  // Single RAM port: grants are mutually exclusive, so one address mux suffices
  always_comb begin
    ram_we   = gnt_mw | gnt_aw;
    ram_re   = (gnt_eq & eq_in_range) | gnt_sw;
    ram_addr = sw_addr;
    ram_din  = bus.mmse_din;
    if (gnt_mw) begin
      ram_addr = mmse_ptr;
    end else if (gnt_aw) begin
      ram_addr = avg_ptr;
      ram_din  = bus.avg_din;
    end else if (gnt_eq) begin
      ram_addr = bus.eq_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end else if (ram_re) begin
      ram_q <= mem[ram_addr];
    end
  end

  always_comb begin
    state_nxt   = state_q;
    sw_addr_nxt = sw_addr;
    done_nxt    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ch_avg_start) begin
          state_nxt   = S_SWEEP;
          sw_addr_nxt = '0;
        end
      end
      S_SWEEP: begin
        if (gnt_sw) begin
          if (sw_addr == MMSE_LAST) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            sw_addr_nxt = sw_addr + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sw_addr    <= '0;
      done_q     <= 1'b0;
      tag_q      <= TAG_NONE;
      err_q      <= 1'b0;
      mmse_ptr   <= '0;
      avg_ptr    <= AVG_BASE;
      eq_hold_q  <= '0;
      avg_hold_q <= '0;
    end else begin
      state_q    <= state_nxt;
      sw_addr    <= sw_addr_nxt;
      done_q     <= done_nxt;
      tag_q      <= gnt_eq ? TAG_EQ : (gnt_sw ? TAG_SW : TAG_NONE);
      err_q      <= gnt_eq & ~eq_in_range;
      eq_hold_q  <= eq_dout;
      avg_hold_q <= avg_dout;
      if (gnt_mw) mmse_ptr <= (mmse_ptr == MMSE_LAST) ? '0 : mmse_ptr + 1'b1;
      if (gnt_aw) avg_ptr  <= (avg_ptr == AVG_LAST) ? AVG_BASE : avg_ptr + 1'b1;
    end
  end

  // The RAM output register is shared; the tag steers it, the idle side replays its last value
  always_comb begin
    eq_dout  = eq_hold_q;
    avg_dout = avg_hold_q;
    if (tag_q == TAG_EQ) eq_dout = err_q ? '0 : ram_q;
    if (tag_q == TAG_SW) avg_dout = ram_q;
  end

  assign bus.eq_rd_vld    = (tag_q == TAG_EQ);
  assign bus.eq_addr_err  = (tag_q == TAG_EQ) & err_q;
  assign bus.eq_ram_dout  = eq_dout;
  assign bus.avg_rd_vld   = (tag_q == TAG_SW);
  assign bus.avg_ram_dout = avg_dout;
  assign bus.avg_rd_done  = done_q;
  assign bus.sweep_busy   = sw_req | done_q;

`ifdef MMSE_RAM_STALL_CNT_EN
  logic [3:0]  req_vec, lost_vec;
  logic [1:0]  n_lost;
  logic [16:0] stall_sum;

  // Each losing requester adds one per cycle
  always_comb begin
    req_vec   = {bus.mmse_wr_vld, bus.avg_wr_vld, bus.eq_rd_en, sw_req};
    lost_vec  = req_vec & ~{gnt_mw, gnt_aw, gnt_eq, gnt_sw};
    n_lost    = 2'(lost_vec[0]) + 2'(lost_vec[1]) + 2'(lost_vec[2]) + 2'(lost_vec[3]);
    stall_sum = {1'b0, stall_cnt} + 17'(n_lost);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else      stall_cnt <= stall_sum[16] ? '1 : stall_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_mmse_ram_arb.sv
// Directed bench for mmse_ram_arb: arbitration table, stream wraps, sweeps, stalls, resets.
module tb_mmse_ram_arb;
  localparam int RW = 32, MD = 576, AD = 240, AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mmse_ram_arb_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();
`ifdef MMSE_RAM_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] cnt0;
`endif

  mmse_ram_arb #(.RAM_WIDTH(RW), .MMSE_DEPTH(MD), .AVG_DEPTH(AD), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MMSE_RAM_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int unsigned n_checks = 0, n_fail = 0;
  logic [31:0] mdl [MD+AD];
  int unsigned m_ptr = 0, a_ptr = MD;

  typedef struct {
    logic m_vld, a_vld, e_en;
    logic m_rdy, a_rdy, e_rdy;
  } arb_vec_t;
  arb_vec_t arb_tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".mmse_wr_rdy"}, bus.mmse_wr_rdy, 0);
    check({tag, ".avg_wr_rdy"}, bus.avg_wr_rdy, 0);
    check({tag, ".eq_rd_rdy"}, bus.eq_rd_rdy, 0);
    check({tag, ".eq_rd_vld"}, bus.eq_rd_vld, 0);
    check({tag, ".eq_ram_dout"}, bus.eq_ram_dout, 0);
    check({tag, ".eq_addr_err"}, bus.eq_addr_err, 0);
    check({tag, ".avg_rd_vld"}, bus.avg_rd_vld, 0);
    check({tag, ".avg_ram_dout"}, bus.avg_ram_dout, 0);
    check({tag, ".avg_rd_done"}, bus.avg_rd_done, 0);
    check({tag, ".sweep_busy"}, bus.sweep_busy, 0);
`ifdef MMSE_RAM_STALL_CNT_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
`endif
  endtask

  task automatic wr(input bit to_avg, input logic [31:0] d);
    @(negedge clk);
    if (to_avg) begin bus.avg_wr_vld = 1'b1; bus.avg_din = d; end
    else        begin bus.mmse_wr_vld = 1'b1; bus.mmse_din = d; end
    #1;
    if (to_avg) check("avg_wr_rdy", bus.avg_wr_rdy, 1);
    else        check("mmse_wr_rdy", bus.mmse_wr_rdy, 1);
    @(posedge clk);
    if (to_avg) begin
      mdl[a_ptr] = d;
      a_ptr = (a_ptr == MD + AD - 1) ? MD : a_ptr + 1;
    end else begin
      mdl[m_ptr] = d;
      m_ptr = (m_ptr == MD - 1) ? 0 : m_ptr + 1;
    end
    #1;
    bus.avg_wr_vld  = 1'b0;
    bus.mmse_wr_vld = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp_d, input logic exp_err);
    @(negedge clk);
    bus.eq_rd_en = 1'b1;
    bus.eq_rd_addr = addr;
    #1 check("eq_rd_rdy", bus.eq_rd_rdy, 1);
    @(negedge clk);
    bus.eq_rd_en = 1'b0;
    check("eq_rd_vld", bus.eq_rd_vld, 1);
    check("eq_ram_dout", bus.eq_ram_dout, exp_d);
    check("eq_addr_err", bus.eq_addr_err, exp_err);
    @(negedge clk);
    check("eq_rd_vld_drop", bus.eq_rd_vld, 0);
    check("eq_addr_err_drop", bus.eq_addr_err, 0);
    check("eq_dout_hold", bus.eq_ram_dout, exp_d);
  endtask

  task automatic start_sweep();
    @(negedge clk);
    bus.ch_avg_start = 1'b1;
    @(negedge clk);
    bus.ch_avg_start = 1'b0;
    check("busy_after_start", bus.sweep_busy, 1);
    check("no_vld_after_start", bus.avg_rd_vld, 0);
  endtask

  task automatic collect(input int unsigned target, input int unsigned budget,
                         output int unsigned gaps, output int unsigned lead);
    int unsigned idx = 0, cyc = 0;
    gaps = 0;
    lead = 0;
    while (idx < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.avg_rd_vld) begin
        check("sweep_data", bus.avg_ram_dout, mdl[idx]);
        check("sweep_done", bus.avg_rd_done, (idx == MD - 1) ? 1 : 0);
        if (idx == MD - 1) check("busy_at_done", bus.sweep_busy, 1);
        idx++;
      end else if (idx > 0) gaps++;
      else lead++;
    end
    check("sweep_beats", idx, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned gaps, lead;
    bus.mmse_wr_vld = 0; bus.mmse_din = '0;
    bus.avg_wr_vld = 0;  bus.avg_din = '0;
    bus.eq_rd_en = 0;    bus.eq_rd_addr = '0;
    bus.ch_avg_start = 0;

    arb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    arb_tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    arb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    arb_tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    arb_tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    arb_tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    arb_tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    arb_tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst = 1'b1;
    @(negedge clk);
    check_zero("after_reset");

    // requests are withdrawn before the clock edge, so the table leaves no state behind
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mmse_wr_vld = arb_tbl[i].m_vld;
      bus.avg_wr_vld  = arb_tbl[i].a_vld;
      bus.eq_rd_en    = arb_tbl[i].e_en;
      bus.eq_rd_addr  = 10'd3;
      #1;
      check($sformatf("arb[%0d].mmse_rdy", i), bus.mmse_wr_rdy, arb_tbl[i].m_rdy);
      check($sformatf("arb[%0d].avg_rdy", i), bus.avg_wr_rdy, arb_tbl[i].a_rdy);
      check($sformatf("arb[%0d].eq_rdy", i), bus.eq_rd_rdy, arb_tbl[i].e_rdy);
      bus.mmse_wr_vld = 0; bus.avg_wr_vld = 0; bus.eq_rd_en = 0;
    end

    for (int k = 0; k < MD; k++) wr(1'b0, 32'(k));
    rd(10'd5, 32'd5, 1'b0);
    rd(10'd575, 32'd575, 1'b0);
    rd(10'd0, 32'd0, 1'b0);
    wr(1'b0, 32'hCAFE_0000);
    rd(10'd0, 32'hCAFE_0000, 1'b0);
    rd(10'd1, 32'd1, 1'b0);

    for (int k = 0; k < AD; k++) wr(1'b1, 32'(1000 + k));
    rd(10'd576, 32'd1000, 1'b0);
    rd(10'd815, 32'd1239, 1'b0);
    wr(1'b1, 32'hBEEF_0000);
    rd(10'd576, 32'hBEEF_0000, 1'b0);
    rd(10'd577, 32'd1001, 1'b0);
    rd(10'd575, 32'd575, 1'b0);

    rd(10'd900, 32'd0, 1'b1);
    rd(10'd816, 32'd0, 1'b1);
    rd(10'd1023, 32'd0, 1'b1);

    start_sweep();
    collect(MD, 2000, gaps, lead);
    check("sweep1_lead", lead, 0);
    check("sweep1_gaps", gaps, 0);
    @(negedge clk);
    check("busy_drop", bus.sweep_busy, 0);
    check("vld_drop", bus.avg_rd_vld, 0);
    check("done_drop", bus.avg_rd_done, 0);

    start_sweep();
    fork
      collect(MD, 2000, gaps, lead);
      begin
        repeat (50) @(negedge clk);
        bus.ch_avg_start = 1'b1;
        @(negedge clk);
        bus.ch_avg_start = 1'b0;
        repeat (50) @(negedge clk);
`ifdef MMSE_RAM_STALL_CNT_EN
        cnt0 = stall_cnt;
`endif
        for (int c = 0; c < 3; c++) begin
          bus.mmse_wr_vld = 1'b1;
          bus.mmse_din = 32'hA5A5_0000 + 32'(c);
          if (c == 1) begin bus.eq_rd_en = 1'b1; bus.eq_rd_addr = 10'd10; end
          #1;
          check("stall_mmse_rdy", bus.mmse_wr_rdy, 1);
          if (c > 0) check("eq_rdy_blocked", bus.eq_rd_rdy, 0);
          @(posedge clk);
          mdl[m_ptr] = bus.mmse_din;
          m_ptr = (m_ptr == MD - 1) ? 0 : m_ptr + 1;
          @(negedge clk);
        end
        bus.mmse_wr_vld = 1'b0;
        #1 check("eq_rdy_after_mmse", bus.eq_rd_rdy, 1);
        @(negedge clk);
        check("stall_eq_vld1", bus.eq_rd_vld, 1);
        check("stall_eq_dout1", bus.eq_ram_dout, mdl[10]);
        bus.eq_rd_addr = 10'd20;
        @(negedge clk);
        bus.eq_rd_en = 1'b0;
        check("stall_eq_vld2", bus.eq_rd_vld, 1);
        check("stall_eq_dout2", bus.eq_ram_dout, mdl[20]);
`ifdef MMSE_RAM_STALL_CNT_EN
        check("stall_cnt_delta", 32'(stall_cnt - cnt0), 7);
`endif
      end
    join
    check("sweep2_lead", lead, 0);
    check("sweep2_gaps", gaps, 5);
    @(negedge clk);
    check("busy_drop2", bus.sweep_busy, 0);

    start_sweep();
    collect(300, 1000, gaps, lead);
    #2 rst = 1'b0;
    #1 check_zero("mid_sweep_reset");
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
    a_ptr = MD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_no_vld", bus.avg_rd_vld, 0);
      check("post_reset_idle", bus.sweep_busy, 0);
    end
    wr(1'b0, 32'h1234_5678);
    rd(10'd0, 32'h1234_5678, 1'b0);

    start_sweep();
    collect(MD, 2000, gaps, lead);
    check("sweep3_lead", lead, 0);
    check("sweep3_gaps", gaps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
